// File: rtl/rom_reader_pkg.sv
// Shared definitions for the IP3601/IP3604 ROM reader datapath.
//   - Chip type codes.
//   - Per-chip last address and data width.
//   - Dump sequencer state encoding.
package rom_reader_pkg;

  localparam logic CHIP_IP3601 = 1'b0;
  localparam logic CHIP_IP3604 = 1'b1;

  localparam int unsigned IP3601_LAST_ADDR  = 255;
  localparam int unsigned IP3604_LAST_ADDR  = 511;
  localparam int unsigned IP3601_DATA_WIDTH = 4;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_ACCESS,
    SEQ_SAMPLE,
    SEQ_PUSH,
    SEQ_DONE
  } seq_state_e;

endpackage

// File: rtl/rom_access_timer.sv
// Loadable down-counter that times the ROM access window.
//   clk_i    board clock
//   rst_ni   asynchronous active-low reset
//   load_i   load ACCESS_CYCLES-1 (takes priority over count_i)
//   count_i  decrement while non-zero
//   zero_o   counter has reached 0
module rom_access_timer #(
  parameter int unsigned ACCESS_CYCLES = 50
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic count_i,
  output logic zero_o
);

  localparam int unsigned CW = $clog2(ACCESS_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(ACCESS_CYCLES - 1);
    end else if (count_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rom_dump_sequencer.sv
// Full-chip ROM dump controller: walks every address of the selected chip,
// waits the access time, samples the data pins and offers each word on a
// valid/ready stream.
//   clk, reset_n                  clock, async active-low reset
//   start, abort                  begin dump (ignored while busy) / stop dump
//   chip_type                     0 = IP3601 (256 x 4), 1 = IP3604 (512 x 8)
//   chip_data_in                  ROM data pins
//   chip_address, chip_select_n   ROM address pins and active-low selects
//   out_data, out_address         sampled word and its address
//   out_valid, out_ready          stream handshake
//   busy, done                    dump in progress / 1-cycle completion pulse
module rom_dump_sequencer
  import rom_reader_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 9,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned SELECT_WIDTH  = 4,
  parameter int unsigned ACCESS_CYCLES = 50
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     chip_type,
  input  logic [DATA_WIDTH-1:0]    chip_data_in,
  output logic [ADDRESS_WIDTH-1:0] chip_address,
  output logic [SELECT_WIDTH-1:0]  chip_select_n,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [ADDRESS_WIDTH-1:0] out_address,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
);

  seq_state_e               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                     type_q, type_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [ADDRESS_WIDTH-1:0] oaddr_q, oaddr_d;

  logic                     timer_load;
  logic                     timer_zero;
  logic [ADDRESS_WIDTH-1:0] last_addr;
  logic [DATA_WIDTH-1:0]    data_mask;
  logic [DATA_WIDTH-1:0]    sampled;
  logic [SELECT_WIDTH-1:0]  sel_pattern;

  rom_access_timer #(
    .ACCESS_CYCLES(ACCESS_CYCLES)
  ) u_timer (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .load_i (timer_load),
    .count_i(state_q == SEQ_ACCESS),
    .zero_o (timer_zero)
  );

  assign last_addr = (type_q == CHIP_IP3604) ? ADDRESS_WIDTH'(IP3604_LAST_ADDR)
                                             : ADDRESS_WIDTH'(IP3601_LAST_ADDR);

  // IP3601 only drives the low nibble; the upper pins float and are discarded.
  always_comb begin
    data_mask = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      data_mask[i] = (i < IP3601_DATA_WIDTH);
    end
    sampled = (type_q == CHIP_IP3604) ? chip_data_in : (chip_data_in & data_mask);
  end

  always_comb begin
    sel_pattern = '0;
    if (type_q == CHIP_IP3601) begin
      sel_pattern      = '1;
      sel_pattern[1:0] = 2'b00;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    type_d     = type_q;
    data_d     = data_q;
    oaddr_d    = oaddr_q;
    timer_load = 1'b0;

    if (abort) begin
      // abort outranks start in IDLE and out_ready in PUSH
      state_d = SEQ_IDLE;
    end else begin
      unique case (state_q)
        SEQ_IDLE: begin
          if (start) begin
            state_d    = SEQ_ACCESS;
            addr_d     = '0;
            type_d     = chip_type;
            timer_load = 1'b1;
          end
        end
        SEQ_ACCESS: begin
          if (timer_zero) state_d = SEQ_SAMPLE;
        end
        SEQ_SAMPLE: begin
          data_d  = sampled;
          oaddr_d = addr_q;
          state_d = SEQ_PUSH;
        end
        SEQ_PUSH: begin
          if (out_ready) begin
            if (addr_q == last_addr) begin
              state_d = SEQ_DONE;
            end else begin
              addr_d     = addr_q + 1'b1;
              timer_load = 1'b1;
              state_d    = SEQ_ACCESS;
            end
          end
        end
        SEQ_DONE: state_d = SEQ_IDLE;
        default:  state_d = SEQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEQ_IDLE;
      addr_q  <= '0;
      type_q  <= CHIP_IP3601;
      data_q  <= '0;
      oaddr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
      data_q  <= data_d;
      oaddr_q <= oaddr_d;
    end
  end

  // Status and select outputs decode straight from registered state, so they
  // follow reset and abort without extra flops.
  assign chip_address  = addr_q;
  assign chip_select_n = ((state_q == SEQ_ACCESS) || (state_q == SEQ_SAMPLE) ||
                          (state_q == SEQ_PUSH)) ? sel_pattern : '1;
  assign out_data      = data_q;
  assign out_address   = oaddr_q;
  assign out_valid     = (state_q == SEQ_PUSH);
  assign busy          = (state_q != SEQ_IDLE);
  assign done          = (state_q == SEQ_DONE);

endmodule
